// File: rtl/sccb_clk_gen.sv
// SCCB/I2C bit-clock generator: idle-high serial clock with fall, low-mid, rise and high-mid
// phase strobes, a run-time loadable half period, and a stop that always finishes the current half.
module sccb_clk_gen #(
  parameter int unsigned CLOCK_FREQ_MHZ = 125,
  parameter int unsigned SCCB_FREQ_KHZ  = 100,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             refclk,
  input  logic             rstn,
  input  logic             en,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_half,
  output logic             sccb_clk,
  output logic             fall_stb,
  output logic             lowmid_stb,
  output logic             rise_stb,
  output logic             highmid_stb,
  output logic             busy,
  output logic             done_stb
);

  localparam int unsigned HALF_CYC = CLOCK_FREQ_MHZ * 500 / SCCB_FREQ_KHZ;

  if (64'(HALF_CYC) >= (64'd1 << CNT_W)) begin : g_half_cyc_too_wide
    $error("sccb_clk_gen: HALF_CYC does not fit in CNT_W bits");
  end

  typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_reg;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] mid;
  logic [CNT_W-1:0] div_clamped;
  logic             half_end;

  assign cnt_inc     = cnt + CNT_W'(1);
  assign mid         = div_reg >> 1;
  assign half_end    = (cnt == div_reg - CNT_W'(1));
  // Half periods below 2 would make an edge strobe and a mid strobe collide.
  assign div_clamped = (div_half < CNT_W'(2)) ? CNT_W'(2) : div_half;

  always_ff @(posedge refclk) begin
    if (!rstn) begin
      state       <= StIdle;
      sccb_clk    <= 1'b1;
      cnt         <= '0;
      div_reg     <= CNT_W'(HALF_CYC);
      fall_stb    <= 1'b0;
      lowmid_stb  <= 1'b0;
      rise_stb    <= 1'b0;
      highmid_stb <= 1'b0;
      busy        <= 1'b0;
      done_stb    <= 1'b0;
    end else begin
      fall_stb    <= 1'b0;
      lowmid_stb  <= 1'b0;
      rise_stb    <= 1'b0;
      highmid_stb <= 1'b0;
      done_stb    <= 1'b0;
      unique case (state)
        StIdle: begin
          cnt <= '0;
          if (div_load) div_reg <= div_clamped;
          if (en) begin
            state    <= StRun;
            sccb_clk <= 1'b0;
            fall_stb <= 1'b1;
            busy     <= 1'b1;
          end
        end
        StRun, StStop: begin
          if (half_end) begin
            cnt <= '0;
            if (state == StStop) begin
              // A pending stop wins over a same-cycle re-enable; the line is left high.
              state    <= StIdle;
              sccb_clk <= 1'b1;
              rise_stb <= ~sccb_clk;
              busy     <= 1'b0;
              done_stb <= 1'b1;
            end else begin
              sccb_clk <= ~sccb_clk;
              rise_stb <= ~sccb_clk;
              fall_stb <= sccb_clk;
              state    <= en ? StRun : StStop;
            end
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == mid) begin
              lowmid_stb  <= ~sccb_clk;
              highmid_stb <= sccb_clk;
            end
            state <= en ? StRun : StStop;
          end
        end
        default: begin
          state    <= StIdle;
          sccb_clk <= 1'b1;
          cnt      <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
